dram_fifo_burst_sched: RTL and testbench

// - Burst scheduler for the DRAM FIFO DMA engine: shares one AXI4 memory port between write (ingress) and read (egress) bursts.
// - Owns the ring-buffer write/read pointers, committed occupancy, partial-burst timeout and burst sizing.
// - Sits between the ingress/egress staging FIFOs and the AXI4 address-channel generators in axis_dram_fifo_single.

---
 rtl/dram_fifo_burst_sched_pkg.sv | 9 +
 rtl/dram_fifo_burst_sched_if.sv | 18 +
 rtl/dram_fifo_burst_sched_len_calc.sv | 31 +++
 rtl/dram_fifo_burst_sched.sv | 101 ++++++++++
 tb/tb_dram_fifo_burst_sched.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/dram_fifo_burst_sched_pkg.sv
// dram_fifo_pkg: shared states, settings-register layout and burst constants for the DRAM FIFO scheduler
package dram_fifo_pkg;
  typedef enum logic [2:0] {IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT} state_e;
  localparam logic [7:0] SR_CTRL_OFS = 8'd0;
  localparam logic [31:0] BOUNDARY_WORDS = 32'd512;
  localparam int CTRL_CLR_BIT = 0;
  localparam int CTRL_TO_LSB = 4;
  localparam int CTRL_TO_W = 12;
endpackage

// File: rtl/dram_fifo_burst_sched_if.sv
// dram_fifo_burst_sched_if: staging-FIFO levels and AXI burst command handshakes around the scheduler
interface dram_fifo_burst_sched_if;
  logic [15:0] wr_avail, rd_space;
  logic wr_cmd_valid, wr_cmd_ready, wr_done;
  logic [31:0] wr_cmd_addr;
  logic [7:0] wr_cmd_len;
  logic rd_cmd_valid, rd_cmd_ready, rd_done;
  logic [31:0] rd_cmd_addr;
  logic [7:0] rd_cmd_len;
  modport master (
    input wr_avail, rd_space, wr_cmd_ready, wr_done, rd_cmd_ready, rd_done,
    output wr_cmd_valid, wr_cmd_addr, wr_cmd_len, rd_cmd_valid, rd_cmd_addr, rd_cmd_len
  );
  modport slave (
    output wr_avail, rd_space, wr_cmd_ready, wr_done, rd_cmd_ready, rd_done,
    input wr_cmd_valid, wr_cmd_addr, wr_cmd_len, rd_cmd_valid, rd_cmd_addr, rd_cmd_len
  );
endinterface

// File: rtl/dram_fifo_burst_sched_len_calc.sv
// dram_fifo_burst_len_calc: clips a burst to source words, max burst, ring wrap, 4 KB page and a limit; registers it on load
module dram_fifo_burst_len_calc import dram_fifo_pkg::*; #(
  parameter int DEPTH_LOG2 = 24,
  parameter int MAX_BURST = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic [31:0] src_i,
  input  logic [31:0] lim_i,
  input  logic [DEPTH_LOG2-1:0] ptr_i,
  output logic [8:0] words_o,
  output logic [8:0] words_q_o,
  output logic [7:0] len_o
);
  logic [31:0] wrap, bnd, m0, m1, m2, m3;
  always_comb begin
    wrap = (32'd1 << DEPTH_LOG2) - 32'(ptr_i);
    bnd = BOUNDARY_WORDS - 32'(ptr_i[8:0]);
    m0 = src_i < 32'(MAX_BURST) ? src_i : 32'(MAX_BURST);
    m1 = m0 < wrap ? m0 : wrap;
    m2 = m1 < bnd ? m1 : bnd;
    m3 = m2 < lim_i ? m2 : lim_i;
    words_o = 9'(m3);
  end
  always_ff @(posedge clk) begin
    if (rst) words_q_o <= '0;
    else if (load_i) words_q_o <= words_o;
  end
  assign len_o = 8'(words_q_o - 9'd1);
endmodule

// File: rtl/dram_fifo_burst_sched.sv
// dram_fifo_burst_sched: arbitrates one AXI port between ring-buffer write and read bursts, tracking pointers and occupancy
module dram_fifo_burst_sched import dram_fifo_pkg::*; #(
  parameter logic [7:0] SR_BASE = 8'd0,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int DEPTH_LOG2 = 24,
  parameter int MAX_BURST = 256
) (
  input  logic bus_clk,
  input  logic bus_rst,
  input  logic clear,
  input  logic set_stb,
  input  logic [7:0] set_addr,
  input  logic [31:0] set_data,
  dram_fifo_burst_sched_if.master bus,
  output logic [DEPTH_LOG2:0] occupied,
  output logic empty,
  output logic full
);
  localparam logic [DEPTH_LOG2:0] CAP = {1'b1, {DEPTH_LOG2{1'b0}}};
  state_e state_q, state_d;
  logic [DEPTH_LOG2-1:0] wp_q, rp_q;
  logic [DEPTH_LOG2:0] occ_q, free;
  logic [CTRL_TO_W-1:0] timer_q, timeout_q;
  logic clr_q, pend_q, last_wr_q, idle, flush, sr_hit, wr_el, rd_el, gw, gr, wr_acc, rd_acc;
  logic [8:0] wr_words, wr_words_q, rd_words, rd_words_q;
  logic [7:0] wr_len, rd_len;
  logic unused_set;
  dram_fifo_burst_len_calc #(.DEPTH_LOG2(DEPTH_LOG2), .MAX_BURST(MAX_BURST)) u_wr_len (
    .clk(bus_clk), .rst(bus_rst), .load_i(gw), .src_i(32'(bus.wr_avail)), .lim_i(32'(free)),
    .ptr_i(wp_q), .words_o(wr_words), .words_q_o(wr_words_q), .len_o(wr_len)
  );
  dram_fifo_burst_len_calc #(.DEPTH_LOG2(DEPTH_LOG2), .MAX_BURST(MAX_BURST)) u_rd_len (
    .clk(bus_clk), .rst(bus_rst), .load_i(gr), .src_i(32'(occ_q)), .lim_i('1),
    .ptr_i(rp_q), .words_o(rd_words), .words_q_o(rd_words_q), .len_o(rd_len)
  );
  assign idle = state_q == IDLE;
  // a clear seen mid-burst is held in pend_q and applied once the burst has finished
  assign flush = clear | clr_q | pend_q;
  assign sr_hit = set_stb && set_addr == SR_BASE + SR_CTRL_OFS;
  assign free = CAP - occ_q;
  assign wr_el = (32'(bus.wr_avail) >= 32'(MAX_BURST) || (bus.wr_avail != '0 && timer_q >= timeout_q)) && free != '0;
  assign rd_el = occ_q != '0 && bus.rd_space >= 16'(rd_words);
  assign gw = idle && !flush && wr_el && (!rd_el || !last_wr_q);
  assign gr = idle && !flush && rd_el && !gw;
  assign wr_acc = state_q == WR_ISSUE && bus.wr_cmd_ready;
  assign rd_acc = state_q == RD_ISSUE && bus.rd_cmd_ready;
  assign bus.wr_cmd_valid = state_q == WR_ISSUE;
  assign bus.wr_cmd_addr = BASE_ADDR + 32'({wp_q, 3'b000});
  assign bus.wr_cmd_len = wr_len;
  assign bus.rd_cmd_valid = state_q == RD_ISSUE;
  assign bus.rd_cmd_addr = BASE_ADDR + 32'({rp_q, 3'b000});
  assign bus.rd_cmd_len = rd_len;
  assign occupied = occ_q;
  assign empty = occ_q == '0;
  assign full = occ_q == CAP;
  assign unused_set = ^{set_data[31:CTRL_TO_LSB+CTRL_TO_W], set_data[CTRL_TO_LSB-1:1]};
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = gw ? WR_ISSUE : gr ? RD_ISSUE : IDLE;
      WR_ISSUE: state_d = bus.wr_cmd_ready ? WR_WAIT : WR_ISSUE;
      WR_WAIT:  state_d = bus.wr_done ? IDLE : WR_WAIT;
      RD_ISSUE: state_d = bus.rd_cmd_ready ? RD_WAIT : RD_ISSUE;
      RD_WAIT:  state_d = bus.rd_done ? IDLE : RD_WAIT;
      default:  state_d = IDLE;
    endcase
  end
  always_ff @(posedge bus_clk) begin
    if (bus_rst) begin
      state_q <= IDLE;
      wp_q <= '0;
      rp_q <= '0;
      occ_q <= '0;
      timer_q <= '0;
      timeout_q <= '0;
      clr_q <= 1'b0;
      pend_q <= 1'b0;
      last_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q <= sr_hit && set_data[CTRL_CLR_BIT];
      if (sr_hit) timeout_q <= set_data[CTRL_TO_LSB +: CTRL_TO_W];
      if (idle && flush) begin
        wp_q <= '0;
        rp_q <= '0;
        occ_q <= '0;
        timer_q <= '0;
        pend_q <= 1'b0;
      end else begin
        pend_q <= pend_q | clear | clr_q;
        if (wr_acc) wp_q <= wp_q + DEPTH_LOG2'(wr_words_q);
        if (rd_acc) rp_q <= rp_q + DEPTH_LOG2'(rd_words_q);
        if (state_q == WR_WAIT && bus.wr_done) occ_q <= occ_q + (DEPTH_LOG2+1)'(wr_words_q);
        else if (rd_acc) occ_q <= occ_q - (DEPTH_LOG2+1)'(rd_words_q);
        if (wr_acc || bus.wr_avail == '0) timer_q <= '0;
        else if (idle && !gw && timer_q != '1) timer_q <= timer_q + CTRL_TO_W'(1);
        if (gw || gr) last_wr_q <= gw;
      end
    end
  end
endmodule

// File: tb/tb_dram_fifo_burst_sched.sv
// tb_dram_fifo_burst_sched: directed burst-sequence checks on a 1024-word ring
module tb_dram_fifo_burst_sched;
  localparam logic [7:0] SR = 8'h10;
  localparam logic [31:0] BASE = 32'h0001_0000;
  typedef struct {
    bit wr;
    logic [15:0] avail;
    logic [15:0] space;
    logic [31:0] addr;
    logic [7:0] len;
    logic [10:0] occ;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;
  logic set_stb = 1'b0;
  logic [7:0] set_addr = '0;
  logic [31:0] set_data = '0;
  logic [10:0] occupied;
  logic empty, full;
  int total = 0;
  int bad = 0;
  vec_t tv [19];
  dram_fifo_burst_sched_if bus();
  dram_fifo_burst_sched #(.SR_BASE(SR), .BASE_ADDR(BASE), .DEPTH_LOG2(10), .MAX_BURST(256)) dut (
    .bus_clk(clk), .bus_rst(rst), .clear(clear), .set_stb(set_stb), .set_addr(set_addr),
    .set_data(set_data), .bus(bus), .occupied(occupied), .empty(empty), .full(full)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic vec_t v(input bit w, input int a, input int s, input int ad, input int ln, input int oc);
    vec_t r;
    r.wr = w;
    r.avail = 16'(a);
    r.space = 16'(s);
    r.addr = 32'(ad);
    r.len = 8'(ln);
    r.occ = 11'(oc);
    return r;
  endfunction
  task automatic set_reg(input logic [31:0] d);
    set_stb = 1'b1;
    set_addr = SR;
    set_data = d;
    tick();
    set_stb = 1'b0;
  endtask
  task automatic issue(input string nm, input bit wr, input logic [31:0] addr, input logic [7:0] len, output int n);
    n = 0;
    while (!(bus.wr_cmd_valid || bus.rd_cmd_valid) && n < 2000) begin
      tick();
      n++;
    end
    if (!(bus.wr_cmd_valid || bus.rd_cmd_valid)) begin
      total++;
      bad++;
      $display("FAIL %s: no command within %0d cycles", nm, n);
      return;
    end
    chk({nm, " kind"}, 32'(bus.wr_cmd_valid), 32'(wr));
    chk({nm, " addr"}, wr ? bus.wr_cmd_addr : bus.rd_cmd_addr, addr);
    chk({nm, " len"}, 32'(wr ? bus.wr_cmd_len : bus.rd_cmd_len), 32'(len));
    if (wr) bus.wr_cmd_ready = 1'b1;
    else bus.rd_cmd_ready = 1'b1;
    tick();
    bus.wr_cmd_ready = 1'b0;
    bus.rd_cmd_ready = 1'b0;
  endtask
  task automatic finish(input bit wr);
    repeat (2) tick();
    if (wr) bus.wr_done = 1'b1;
    else bus.rd_done = 1'b1;
    tick();
    bus.wr_done = 1'b0;
    bus.rd_done = 1'b0;
  endtask
  task automatic quiet(input string nm, input int cyc);
    logic seen;
    seen = 1'b0;
    repeat (cyc) begin
      tick();
      seen = seen | bus.wr_cmd_valid | bus.rd_cmd_valid;
    end
    chk(nm, 32'(seen), 32'd0);
  endtask
  task automatic run_vec(input int i);
    int n;
    bus.wr_avail = tv[i].avail;
    bus.rd_space = tv[i].space;
    issue($sformatf("v%0d", i), tv[i].wr, tv[i].addr, tv[i].len, n);
    finish(tv[i].wr);
    chk($sformatf("v%0d occ", i), 32'(occupied), 32'(tv[i].occ));
  endtask
  initial begin
    int n;
    tv[0] = v(0, 0, 300, 'h10000, 255, 76);
    tv[1] = v(0, 0, 300, 'h10800, 75, 0);
    tv[2] = v(1, 300, 0, 'h10A60, 179, 180);
    tv[3] = v(1, 300, 0, 'h11000, 255, 436);
    tv[4] = v(1, 232, 0, 'h11800, 231, 668);
    tv[5] = v(1, 256, 0, 'h11F40, 23, 692);
    tv[6] = v(1, 232, 0, 'h10000, 231, 924);
    tv[7] = v(1, 300, 0, 'h10740, 99, 1024);
    tv[8] = v(0, 0, 300, 'h10A60, 179, 844);
    tv[9] = v(1, 100, 0, 'h10A60, 99, 944);
    tv[10] = v(0, 300, 300, 'h11000, 255, 688);
    tv[11] = v(1, 300, 300, 'h10D80, 79, 768);
    tv[12] = v(0, 300, 300, 'h11800, 255, 512);
    tv[13] = v(1, 300, 300, 'h11000, 255, 768);
    tv[14] = v(0, 0, 300, 'h10000, 255, 512);
    tv[15] = v(0, 0, 300, 'h10800, 255, 256);
    tv[16] = v(0, 0, 300, 'h11000, 255, 0);
    tv[17] = v(1, 20, 0, 'h11800, 19, 20);
    tv[18] = v(0, 0, 20, 'h11800, 19, 0);
    bus.wr_avail = '0;
    bus.rd_space = '0;
    bus.wr_cmd_ready = 1'b0;
    bus.rd_cmd_ready = 1'b0;
    bus.wr_done = 1'b0;
    bus.rd_done = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst occ", 32'(occupied), 32'd0);
    chk("rst empty", 32'(empty), 32'd1);
    chk("rst full", 32'(full), 32'd0);
    chk("rst wr valid", 32'(bus.wr_cmd_valid), 32'd0);
    chk("rst rd valid", 32'(bus.rd_cmd_valid), 32'd0);
    set_reg(32'd20 << 4);
    bus.wr_avail = 16'd300;
    repeat (5) tick();
    chk("issue holds valid", 32'(bus.wr_cmd_valid), 32'd1);
    issue("w0", 1'b1, BASE, 8'd255, n);
    bus.wr_avail = 16'd44;
    finish(1'b1);
    chk("w0 occ", 32'(occupied), 32'd256);
    issue("w1", 1'b1, BASE + 32'h800, 8'd43, n);
    chk("w1 timeout wait", 32'(n), 32'd21);
    bus.wr_avail = '0;
    finish(1'b1);
    chk("w1 occ", 32'(occupied), 32'd300);
    set_reg(32'd280 << 4);
    bus.wr_avail = 16'd16;
    issue("w2", 1'b1, 32'h10960, 8'd15, n);
    chk("w2 timeout wait", 32'(n), 32'd281);
    set_reg(32'd0);
    finish(1'b1);
    chk("w2 occ", 32'(occupied), 32'd316);
    issue("w3", 1'b1, 32'h109E0, 8'd15, n);
    chk("w3 zero timeout wait", 32'(n), 32'd1);
    finish(1'b1);
    chk("w3 occ", 32'(occupied), 32'd332);
    for (int i = 0; i < 8; i++) run_vec(i);
    chk("ring full", 32'(full), 32'd1);
    chk("ring full not empty", 32'(empty), 32'd0);
    quiet("no write when full", 50);
    run_vec(8);
    chk("full cleared by read", 32'(full), 32'd0);
    for (int i = 9; i < 18; i++) run_vec(i);
    bus.wr_avail = '0;
    bus.rd_space = 16'd10;
    quiet("no read when space short", 30);
    run_vec(18);
    bus.wr_avail = 16'd50;
    bus.rd_space = '0;
    issue("wc", 1'b1, 32'h118A0, 8'd49, n);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    bus.wr_avail = '0;
    bus.rd_space = 16'd300;
    finish(1'b1);
    repeat (2) tick();
    chk("clear occ", 32'(occupied), 32'd0);
    chk("clear empty", 32'(empty), 32'd1);
    quiet("no cmd after clear", 20);
    bus.wr_avail = 16'd8;
    issue("w after clear", 1'b1, BASE, 8'd7, n);
    bus.wr_avail = '0;
    bus.rd_space = '0;
    finish(1'b1);
    chk("w after clear occ", 32'(occupied), 32'd8);
    set_reg(32'd1);
    repeat (2) tick();
    chk("sr clear occ", 32'(occupied), 32'd0);
    chk("sr clear empty", 32'(empty), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
